umtrx_tx_burst_pacer: RTL and testbench
=======================================

// Module: umtrx_tx_burst_pacer
// PURPOSE
//  Multi-channel timed-burst sample pacer for the UmTRX TX path; sits between the per-channel sample streams and the DUC inputs.
//  Per channel: starts bursts at a programmed VITA time, paces samples on the DUC strobe, and rounds/saturates them to DAC_W.
//  Reports burst-ACK, underflow and late-start events through a shared event FIFO.
//  Generalises the single-channel, fixed-12-bit-truncation TX chain to NCH channels, configurable widths and timed starts.
// PARAMETERS
//  NCH      2    number of TX channels (1..8)
//  SAMP_W   16   input I/Q component width, signed
//  DAC_W    12   output I/Q component width, signed, DAC_W <= SAMP_W
//  BASE     0    settings-bus base address
//  EVT_AW   4    event FIFO address width (depth 2**EVT_AW)
// PORTS
//  clk         in   1            single clock for all logic
//  rst_n       in   1            asynchronous active-low reset
//  set_stb     in   1            settings write strobe
//  set_addr    in   8            settings address
//  set_data    in   32           settings data
//  vita_time   in   64           current VITA time, clk domain
//  strobe      in   1            common DUC sample strobe
//  s_tdata     in   NCH*2*SAMP_W {I,Q} per channel, ch0 in LSBs
//  s_tvalid    in   NCH          per-channel valid
//  s_tready    out  NCH          per-channel ready
//  s_tlast     in   NCH          last sample of burst
//  s_thas_time in   NCH          burst head carries start time (sampled with first beat only)
//  s_ttime     in   NCH*64       burst start time
//  sample      out  NCH*2*DAC_W  rounded {I,Q} to DUC
//  run         out  NCH          channel actively bursting
//  evt_tdata   out  72           {chan[3:0], code[3:0], time[63:0]}
//  evt_tvalid  out  1            event valid
//  evt_tready  in   1            event accept
// BEHAVIOUR
//  Reset: sample=0, run=0, s_tready=0, evt_tvalid=0, all channels IDLE, enable mask=0, pending flags clear, FIFO empty.
//  Registers: BASE+0 enable mask [NCH-1:0]; BASE+1 clear mask, write-pulse, self-clearing.
//  Per-channel FSM IDLE/WAIT/RUN:
//   IDLE: run=0, sample=0. Enabled & s_tvalid: s_thas_time=1 -> WAIT, latch s_ttime; else -> RUN (head not consumed).
//   WAIT: on strobe with vita_time==latched -> RUN, consume head that cycle.
//         Late (vita_time>latched) -> raise LATE(4) with time=vita_time, consume & discard to tlast, -> IDLE.
//   RUN: on strobe, if s_tvalid: s_tready=1 that cycle, sample registered next cycle, run=1 same cycle as first sample.
//        tlast consumed -> raise ACK(1), -> IDLE after that beat.
//        strobe & !s_tvalid: sample=0, raise UNDERFLOW(2) once per burst (sticky until tlast), stay RUN.
//  s_tready is 1 only on consuming strobe cycles or during late-discard; never in IDLE.
//  Clear or enable bit drop: channel -> IDLE next cycle, sticky/latched time dropped, pending event kept.
//  Rounding, per component: x + 2**(SAMP_W-DAC_W-1), take top DAC_W bits, saturate to +2**(DAC_W-1)-1; DAC_W==SAMP_W passes through.
//  Events: per-channel per-code pending bit + captured time; same code re-raised while pending merges (no second entry).
//  Arbiter: lowest-index channel with pending, then lowest code; one FIFO write per cycle when not full; pending cleared on write.
//  FIFO full: pending bits hold, no loss, FSMs not stalled.
//  evt_tdata stable while evt_tvalid & !evt_tready.
//  Latency: strobe -> sample 1 cycle; raise -> evt_tvalid >= 2 cycles when FIFO empty.
// STRUCTURE
//  Shared include umtrx_tx_defs.vh: event codes ACK=1, UNDERFLOW=2, LATE=4, FSM state encodings, register offsets.
//  Sub-module: umtrx_evt_fifo (sync FWFT FIFO, 72 bits, depth 2**EVT_AW, async active-low reset).
//  Per-channel FSM and rounding in a generate loop; arbiter in top.
// TESTING
//  Untimed 4-beat burst ch0, strobe every 4 clk -> 4 samples, run high 4 strobes, one ACK chan0.
//  Timed burst t=1000, vita_time 990 -> first sample at strobe with time 1000, run low before.
//  Timed burst t=500 arriving at time 600 -> LATE event time=600, burst discarded, run never high.
//  Valid drops 2 strobes mid-burst -> sample=0 those strobes, exactly one UNDERFLOW event, ACK at tlast.
//  Rounding SAMP_W=16, DAC_W=12: 0x7FF8 -> 0x7FF, 0x0008 -> 0x001, 0xFFF7 -> 0xFFF, 0x8000 -> 0x800.
//  ch0 and ch1 ACK same cycle, evt_tready=0 then 1 -> ch0 then ch1 event, none lost; rst_n low mid-burst -> all outputs 0.

Source files
------------

// File: rtl/umtrx_tx_burst_pacer_pkg.sv
// Shared definitions for the UmTRX TX burst pacer: channel FSM states,
// event codes, settings register offsets and the event record width.
package umtrx_tx_burst_pacer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RUN     = 2'd2,
      ST_DISCARD = 2'd3
   } chan_state_e;

   localparam logic [3:0] EVT_ACK       = 4'd1;
   localparam logic [3:0] EVT_UNDERFLOW = 4'd2;
   localparam logic [3:0] EVT_LATE      = 4'd4;

   // Per-channel pending-bit index of each event kind; lower index wins arbitration.
   localparam int EVT_KINDS         = 3;
   localparam int EVT_IDX_ACK       = 0;
   localparam int EVT_IDX_UNDERFLOW = 1;
   localparam int EVT_IDX_LATE      = 2;

   localparam logic [7:0] REG_ENABLE = 8'd0;
   localparam logic [7:0] REG_CLEAR  = 8'd1;

   localparam int EVT_W = 72;

   function automatic logic [3:0] evt_code(input logic [1:0] idx);
      case (idx)
         2'd0:    return EVT_ACK;
         2'd1:    return EVT_UNDERFLOW;
         default: return EVT_LATE;
      endcase
   endfunction

endpackage

// File: rtl/umtrx_evt_fifo.sv
// Synchronous first-word-fall-through FIFO holding pacer event records.
// Head word is visible on rd_data whenever rd_valid is high and holds until popped.
module umtrx_evt_fifo
   import umtrx_tx_burst_pacer_pkg::*;
#(
   parameter int W  = EVT_W,
   parameter int AW = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] wr_data,
   input  logic         wr_en,
   output logic         full,
   output logic [W-1:0] rd_data,
   output logic         rd_valid,
   input  logic         rd_ready
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign full     = (count == (AW+1)'(DEPTH));
   assign rd_valid = (count != '0);
   assign rd_data  = mem[rd_ptr];
   assign do_wr    = wr_en && !full;
   assign do_rd    = rd_valid && rd_ready;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

endmodule

// File: rtl/umtrx_tx_burst_pacer.sv
// Multi-channel timed-burst pacer: starts bursts at a VITA time, paces samples on the
// DUC strobe, rounds/saturates to DAC_W and reports ACK/UNDERFLOW/LATE events.
module umtrx_tx_burst_pacer
   import umtrx_tx_burst_pacer_pkg::*;
#(
   parameter int NCH    = 2,
   parameter int SAMP_W = 16,
   parameter int DAC_W  = 12,
   parameter int BASE   = 0,
   parameter int EVT_AW = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    set_stb,
   input  logic [7:0]              set_addr,
   input  logic [31:0]             set_data,
   input  logic [63:0]             vita_time,
   input  logic                    strobe,
   input  logic [NCH*2*SAMP_W-1:0] s_tdata,
   input  logic [NCH-1:0]          s_tvalid,
   output logic [NCH-1:0]          s_tready,
   input  logic [NCH-1:0]          s_tlast,
   input  logic [NCH-1:0]          s_thas_time,
   input  logic [NCH*64-1:0]       s_ttime,
   output logic [NCH*2*DAC_W-1:0]  sample,
   output logic [NCH-1:0]          run,
   output logic [EVT_W-1:0]        evt_tdata,
   output logic                    evt_tvalid,
   input  logic                    evt_tready,
   output logic [NCH*2-1:0]        dbg_state
);

   localparam logic [7:0] ADDR_ENABLE = 8'(BASE) + REG_ENABLE;
   localparam logic [7:0] ADDR_CLEAR  = 8'(BASE) + REG_CLEAR;

   logic [NCH-1:0]       enable_mask;
   logic [NCH-1:0]       clear_hit;
   logic [EVT_KINDS-1:0] raise     [NCH];
   logic [EVT_KINDS-1:0] pend      [NCH];
   logic [EVT_KINDS-1:0] taken     [NCH];
   logic [63:0]          pend_time [NCH][EVT_KINDS];

   logic                 grant_valid;
   logic [3:0]           grant_chan;
   logic [1:0]           grant_kind;
   logic [63:0]          grant_time;
   logic                 fifo_wr;
   logic                 fifo_full;
   logic [EVT_W-1:0]     fifo_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) enable_mask <= '0;
      else if (set_stb && set_addr == ADDR_ENABLE) enable_mask <= NCH'(set_data);
   end

   // Clear acts only in the write cycle; nothing is stored for it.
   assign clear_hit = (set_stb && set_addr == ADDR_CLEAR) ? NCH'(set_data) : '0;

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      chan_state_e          state;
      chan_state_e          state_n;
      logic [63:0]          t_start;
      logic                 sticky;
      logic [2*DAC_W-1:0]   samp_q;
      logic                 run_q;
      logic                 kill, ready, load, blank, zero, latch;
      logic                 set_sticky, clr_sticky;
      logic [EVT_KINDS-1:0] ch_raise;
      logic [SAMP_W-1:0]    in_i, in_q;
      logic [DAC_W-1:0]     out_i, out_q;

      assign in_i = s_tdata[c*2*SAMP_W + SAMP_W +: SAMP_W];
      assign in_q = s_tdata[c*2*SAMP_W +: SAMP_W];
      assign kill = clear_hit[c] || !enable_mask[c];

      if (SAMP_W == DAC_W) begin : g_pass
         assign out_i = in_i;
         assign out_q = in_q;
      end else begin : g_round
         localparam int SH = SAMP_W - DAC_W;
         localparam logic [SAMP_W:0]  HALF = (SAMP_W+1)'(1) << (SH - 1);
         localparam logic [DAC_W-1:0] MAXV = {1'b0, {(DAC_W-1){1'b1}}};
         logic [SAMP_W:0] sum_i, sum_q;
         // Only positive values can overflow after adding the half-LSB.
         assign sum_i = {in_i[SAMP_W-1], in_i} + HALF;
         assign sum_q = {in_q[SAMP_W-1], in_q} + HALF;
         assign out_i = (sum_i[SAMP_W:SAMP_W-1] == 2'b01) ? MAXV : DAC_W'(sum_i >> SH);
         assign out_q = (sum_q[SAMP_W:SAMP_W-1] == 2'b01) ? MAXV : DAC_W'(sum_q >> SH);
      end

      always_comb begin
         state_n    = state;
         ready      = 1'b0;
         load       = 1'b0;
         blank      = 1'b0;
         zero       = 1'b0;
         latch      = 1'b0;
         set_sticky = 1'b0;
         clr_sticky = 1'b0;
         ch_raise   = '0;
         if (kill) begin
            state_n    = ST_IDLE;
            zero       = 1'b1;
            clr_sticky = 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  zero = strobe;
                  if (s_tvalid[c]) begin
                     if (s_thas_time[c]) begin
                        state_n = ST_WAIT;
                        latch   = 1'b1;
                     end else begin
                        state_n = ST_RUN;
                     end
                  end
               end
               ST_WAIT: begin
                  if (vita_time > t_start) begin
                     ch_raise[EVT_IDX_LATE] = 1'b1;
                     state_n = ST_DISCARD;
                     zero    = strobe;
                  end else if (strobe && vita_time == t_start && s_tvalid[c]) begin
                     ready = 1'b1;
                     load  = 1'b1;
                     if (s_tlast[c]) begin
                        ch_raise[EVT_IDX_ACK] = 1'b1;
                        state_n = ST_IDLE;
                     end else begin
                        state_n = ST_RUN;
                     end
                  end else begin
                     zero = strobe;
                  end
               end
               ST_RUN: begin
                  if (strobe) begin
                     if (s_tvalid[c]) begin
                        ready = 1'b1;
                        load  = 1'b1;
                        if (s_tlast[c]) begin
                           ch_raise[EVT_IDX_ACK] = 1'b1;
                           clr_sticky = 1'b1;
                           state_n    = ST_IDLE;
                        end
                     end else begin
                        // Starved strobe: output silence, report only the first per burst.
                        blank = 1'b1;
                        if (!sticky) begin
                           ch_raise[EVT_IDX_UNDERFLOW] = 1'b1;
                           set_sticky = 1'b1;
                        end
                     end
                  end
               end
               ST_DISCARD: begin
                  ready = 1'b1;
                  zero  = strobe;
                  if (s_tvalid[c] && s_tlast[c]) state_n = ST_IDLE;
               end
               default: state_n = ST_IDLE;
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state   <= ST_IDLE;
            t_start <= '0;
            sticky  <= 1'b0;
            samp_q  <= '0;
            run_q   <= 1'b0;
         end else begin
            state <= state_n;
            if (kill)       t_start <= '0;
            else if (latch) t_start <= s_ttime[c*64 +: 64];
            if (clr_sticky)      sticky <= 1'b0;
            else if (set_sticky) sticky <= 1'b1;
            // Sample and run hold until the next strobe so every sample spans a full strobe period.
            if (load) begin
               samp_q <= {out_i, out_q};
               run_q  <= 1'b1;
            end else if (blank) begin
               samp_q <= '0;
            end else if (zero) begin
               samp_q <= '0;
               run_q  <= 1'b0;
            end
         end
      end

      assign s_tready[c]                    = ready;
      assign sample[c*2*DAC_W +: 2*DAC_W]   = samp_q;
      assign run[c]                         = run_q;
      assign dbg_state[c*2 +: 2]            = state;
      assign raise[c]                       = ch_raise;
   end

   // Lowest channel first, then lowest code; later loop iterations override earlier ones.
   always_comb begin
      grant_valid = 1'b0;
      grant_chan  = '0;
      grant_kind  = '0;
      grant_time  = '0;
      for (int c = NCH - 1; c >= 0; c--) begin
         for (int k = EVT_KINDS - 1; k >= 0; k--) begin
            if (pend[c][k]) begin
               grant_valid = 1'b1;
               grant_chan  = 4'(c);
               grant_kind  = 2'(k);
               grant_time  = pend_time[c][k];
            end
         end
      end
   end

   assign fifo_wr    = grant_valid && !fifo_full;
   assign fifo_wdata = {grant_chan, evt_code(grant_kind), grant_time};

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         taken[c] = '0;
         for (int k = 0; k < EVT_KINDS; k++) begin
            taken[c][k] = fifo_wr && grant_chan == 4'(c) && grant_kind == 2'(k);
         end
      end
   end

   // A raise merges into an already pending entry and keeps its original time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            pend[c] <= '0;
            for (int k = 0; k < EVT_KINDS; k++) pend_time[c][k] <= '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < EVT_KINDS; k++) begin
               pend[c][k] <= raise[c][k] || (pend[c][k] && !taken[c][k]);
               if (raise[c][k] && (!pend[c][k] || taken[c][k])) pend_time[c][k] <= vita_time;
            end
         end
      end
   end

   umtrx_evt_fifo #(
      .W  (EVT_W),
      .AW (EVT_AW)
   ) u_evt_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_data  (fifo_wdata),
      .wr_en    (fifo_wr),
      .full     (fifo_full),
      .rd_data  (evt_tdata),
      .rd_valid (evt_tvalid),
      .rd_ready (evt_tready)
   );

endmodule

// File: tb/tb_umtrx_tx_burst_pacer.sv
// Directed bench for umtrx_tx_burst_pacer: table-driven rounding burst plus
// hand-written timed, late, underflow, dual-ACK and reset sequences.
module tb_umtrx_tx_burst_pacer;

   localparam int NCH    = 2;
   localparam int SAMP_W = 16;
   localparam int DAC_W  = 12;

   logic                    clk;
   logic                    rst_n;
   logic                    set_stb;
   logic [7:0]              set_addr;
   logic [31:0]             set_data;
   logic [63:0]             vita_time;
   logic                    strobe;
   logic [NCH*2*SAMP_W-1:0] s_tdata;
   logic [NCH-1:0]          s_tvalid;
   logic [NCH-1:0]          s_tready;
   logic [NCH-1:0]          s_tlast;
   logic [NCH-1:0]          s_thas_time;
   logic [NCH*64-1:0]       s_ttime;
   logic [NCH*2*DAC_W-1:0]  sample;
   logic [NCH-1:0]          run;
   logic [71:0]             evt_tdata;
   logic                    evt_tvalid;
   logic                    evt_tready;
   logic [NCH*2-1:0]        dbg_state;

   umtrx_tx_burst_pacer #(
      .NCH(NCH), .SAMP_W(SAMP_W), .DAC_W(DAC_W), .BASE(0), .EVT_AW(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .set_stb(set_stb), .set_addr(set_addr),
      .set_data(set_data), .vita_time(vita_time), .strobe(strobe),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_tlast(s_tlast), .s_thas_time(s_thas_time), .s_ttime(s_ttime),
      .sample(sample), .run(run), .evt_tdata(evt_tdata), .evt_tvalid(evt_tvalid),
      .evt_tready(evt_tready), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] i;
      logic [15:0] q;
      logic        last;
      logic        head;
      int          gap;
   } beat_t;

   typedef struct {
      logic        run;
      logic [23:0] smp;
      logic [63:0] t;
   } log_t;

   typedef struct {
      logic [15:0] i;
      logic [15:0] q;
      logic [11:0] ei;
      logic [11:0] eq;
   } vec_t;

   beat_t       src0[$];
   beat_t       src1[$];
   int          hold0, hold1;
   logic [63:0] ttime_v [NCH];
   log_t        slog[$];
   logic [71:0] exp_q[$];
   logic [71:0] mask_q[$];
   vec_t        vecs [4];
   int          n_tests, n_fail, cyc;
   logic        vita_run, run_seen0;

   localparam logic [71:0] M_CODE = {8'hFF, 64'd0};
   localparam logic [71:0] M_FULL = {72{1'b1}};

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_evt(input logic [3:0] ch, input logic [3:0] code,
                             input logic [63:0] t, input logic [71:0] m);
      exp_q.push_back({ch, code, t});
      mask_q.push_back(m);
   endtask

   task automatic sb_pop();
      logic [71:0] e, m;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL evt_unexpected: got %0h expected no event", evt_tdata);
      end else begin
         e = exp_q.pop_front();
         m = mask_q.pop_front();
         check("evt", evt_tdata & m, e & m);
      end
   endtask

   task automatic push(input int ch, input logic [15:0] i, input logic [15:0] q,
                       input logic last, input logic head, input int gap);
      beat_t b;
      b.i = i; b.q = q; b.last = last; b.head = head; b.gap = gap;
      if (ch == 0) src0.push_back(b);
      else         src1.push_back(b);
   endtask

   task automatic present();
      s_tvalid    = '0;
      s_tlast     = '0;
      s_thas_time = '0;
      s_tdata     = '0;
      if (src0.size() > 0 && hold0 == 0) begin
         s_tvalid[0] = 1'b1;
         s_tdata[31:0] = {src0[0].i, src0[0].q};
         s_tlast[0] = src0[0].last;
         s_thas_time[0] = src0[0].head;
      end
      if (src1.size() > 0 && hold1 == 0) begin
         s_tvalid[1] = 1'b1;
         s_tdata[63:32] = {src1[0].i, src1[0].q};
         s_tlast[1] = src1[0].last;
         s_thas_time[1] = src1[0].head;
      end
      s_ttime = {ttime_v[1], ttime_v[0]};
   endtask

   // One clock: handshakes observed at negedge, outputs sampled 1 ns after posedge.
   task automatic step();
      logic f0, f1, sw;
      @(negedge clk);
      f0 = s_tvalid[0] & s_tready[0];
      f1 = s_tvalid[1] & s_tready[1];
      if (evt_tvalid && evt_tready) sb_pop();
      @(posedge clk);
      #1;
      sw = strobe;
      if (run[0]) run_seen0 = 1'b1;
      if (sw) begin
         slog.push_back('{run[0], sample[23:0], vita_time});
         if (vita_run) vita_time = vita_time + 64'd1;
      end
      if (f0) begin
         void'(src0.pop_front());
         hold0 = (src0.size() > 0) ? src0[0].gap : 0;
      end else if (sw && hold0 > 0) hold0--;
      if (f1) begin
         void'(src1.pop_front());
         hold1 = (src1.size() > 0) ? src1[0].gap : 0;
      end else if (sw && hold1 > 0) hold1--;
      cyc++;
      strobe = (cyc % 4 == 3);
      present();
   endtask

   task automatic set_reg(input logic [7:0] addr, input logic [31:0] data);
      set_stb = 1'b1; set_addr = addr; set_data = data;
      step();
      set_stb = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while ((src0.size() > 0 || src1.size() > 0 || run != '0) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got %0d cycles expected < %0d", name, n, budget);
      end
      repeat (10) step();
   endtask

   initial begin
      int k, bad, first_t;
      logic [23:0] exp_s[$];
      n_tests = 0; n_fail = 0; cyc = 0;
      rst_n = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
      vita_time = 64'd0; vita_run = 1'b1; strobe = 1'b0; evt_tready = 1'b1;
      hold0 = 0; hold1 = 0; ttime_v[0] = '0; ttime_v[1] = '0; run_seen0 = 1'b0;
      present();
      repeat (3) @(posedge clk);
      #1;
      check("rst_sample", sample, 0);
      check("rst_run", run, 0);
      check("rst_tready", s_tready, 0);
      check("rst_evt_tvalid", evt_tvalid, 0);
      check("rst_state", dbg_state, 0);
      rst_n = 1'b1;
      step();

      // Untimed 4-beat burst on ch0 carrying the rounding table.
      vecs[0] = '{16'h7FF8, 16'h1234, 12'h7FF, 12'h123};
      vecs[1] = '{16'h0008, 16'hFFFF, 12'h001, 12'h000};
      vecs[2] = '{16'hFFF7, 16'h0007, 12'hFFF, 12'h000};
      vecs[3] = '{16'h8000, 16'h7FF7, 12'h800, 12'h7FF};
      set_reg(8'd0, 32'd1);
      slog.delete();
      expect_evt(4'd0, 4'd1, 64'd0, M_CODE);
      for (int i = 0; i < 4; i++) push(0, vecs[i].i, vecs[i].q, i == 3, 1'b0, 0);
      hold0 = 0;
      present();
      wait_done("untimed", 200);
      k = 0;
      foreach (slog[j]) begin
         if (slog[j].run) begin
            if (k < 4) check($sformatf("round_vec%0d", k), slog[j].smp, {vecs[k].ei, vecs[k].eq});
            k++;
         end
      end
      check("untimed_run_strobes", k, 4);
      check("untimed_idle_sample", sample[23:0], 0);

      // Timed burst at 1000 while VITA time starts at 990.
      vita_time = 64'd990;
      slog.delete();
      ttime_v[0] = 64'd1000;
      expect_evt(4'd0, 4'd1, 64'd1002, M_FULL);
      for (int i = 0; i < 3; i++) push(0, 16'h0100, 16'h0200, i == 2, i == 0, 0);
      hold0 = 0;
      present();
      wait_done("timed", 300);
      k = 0; bad = 0; first_t = -1;
      foreach (slog[j]) begin
         if (slog[j].run) begin
            if (k == 0) first_t = int'(slog[j].t);
            k++;
         end else if (k == 0 && j > 0 && slog[j].t >= 64'd1000) bad++;
      end
      check("timed_first_sample_time", first_t, 1000);
      check("timed_run_strobes", k, 3);
      check("timed_run_low_before", bad, 0);

      // Timed burst at 500 arriving at 600: late and discarded.
      vita_run = 1'b0;
      vita_time = 64'd600;
      ttime_v[0] = 64'd500;
      run_seen0 = 1'b0;
      expect_evt(4'd0, 4'd4, 64'd600, M_FULL);
      for (int i = 0; i < 3; i++) push(0, 16'h1000, 16'h1000, i == 2, i == 0, 0);
      hold0 = 0;
      present();
      wait_done("late", 100);
      check("late_run_never", run_seen0, 0);
      check("late_discarded", src0.size(), 0);
      vita_run = 1'b1;
      ttime_v[0] = '0;

      // Valid withheld for two strobes mid-burst.
      slog.delete();
      expect_evt(4'd0, 4'd2, 64'd0, M_CODE);
      expect_evt(4'd0, 4'd1, 64'd0, M_CODE);
      exp_s.delete();
      for (int i = 1; i <= 6; i++) begin
         push(0, 16'(i * 16), 16'(-(i * 16)), i == 6, 1'b0, (i == 3) ? 2 : 0);
         if (i == 3) begin
            exp_s.push_back(24'd0);
            exp_s.push_back(24'd0);
         end
         exp_s.push_back({12'(i), 12'(-i)});
      end
      hold0 = 0;
      present();
      wait_done("underflow", 300);
      k = 0;
      foreach (slog[j]) begin
         if (slog[j].run) begin
            if (k < exp_s.size()) check($sformatf("uflow_strobe%0d", k), slog[j].smp, exp_s[k]);
            k++;
         end
      end
      check("uflow_run_strobes", k, 8);

      // Both channels ACK in the same cycle while the event sink is stalled.
      set_reg(8'd0, 32'd3);
      evt_tready = 1'b0;
      expect_evt(4'd0, 4'd1, 64'd0, M_CODE);
      expect_evt(4'd1, 4'd1, 64'd0, M_CODE);
      for (int i = 0; i < 2; i++) begin
         push(0, 16'h0040, 16'h0040, i == 1, 1'b0, 0);
         push(1, 16'h0080, 16'h0080, i == 1, 1'b0, 0);
      end
      hold0 = 0; hold1 = 0;
      present();
      wait_done("dual", 200);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("dual_hold_valid%0d", i), evt_tvalid, 1);
         check($sformatf("dual_hold_head%0d", i), evt_tdata[71:64], 8'h01);
         step();
      end
      evt_tready = 1'b1;
      repeat (5) step();
      check("dual_none_lost", exp_q.size(), 0);

      // Reset asserted in the middle of a burst.
      for (int i = 0; i < 6; i++) push(0, 16'h0400, 16'h0400, i == 5, 1'b0, 0);
      hold0 = 0;
      present();
      k = 0;
      while (!run[0] && k < 50) begin
         step();
         k++;
      end
      check("midrst_started", run[0], 1);
      step();
      rst_n = 1'b0;
      #1;
      check("midrst_sample", sample, 0);
      check("midrst_run", run, 0);
      check("midrst_tready", s_tready, 0);
      check("midrst_evt_tvalid", evt_tvalid, 0);
      src0.delete();
      src1.delete();
      hold0 = 0; hold1 = 0;
      present();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) step();
      check("evt_drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
